// File: rtl/cpu_pkg.sv
// Shared opcode constants, instruction-type classification and loader FSM encoding.
package cpu_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_C1   = 4'b0001;
    localparam logic [3:0] OP_C2   = 4'b0010;
    localparam logic [3:0] OP_C4   = 4'b0100;
    localparam logic [3:0] OP_C5   = 4'b0101;
    localparam logic [3:0] OP_C6   = 4'b0110;
    localparam logic [3:0] OP_D7   = 4'b0111;
    localparam logic [3:0] OP_B10  = 4'b1010;
    localparam logic [3:0] OP_B11  = 4'b1011;
    localparam logic [3:0] OP_B12  = 4'b1100;
    localparam logic [3:0] OP_B13  = 4'b1101;
    localparam logic [3:0] OP_A15  = 4'b1111;

    typedef enum logic [2:0] {
        ITYPE_A,
        ITYPE_B,
        ITYPE_C,
        ITYPE_D,
        ITYPE_UNDEF
    } itype_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic itype_e classify(input logic [3:0] op);
        case (op)
            OP_A15:                          return ITYPE_A;
            OP_B10, OP_B11, OP_B12, OP_B13:  return ITYPE_B;
            OP_C1, OP_C2, OP_C4, OP_C5, OP_C6: return ITYPE_C;
            OP_D7, OP_HALT:                  return ITYPE_D;
            default:                         return ITYPE_UNDEF;
        endcase
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational instruction packer: builds the 16-bit memory word from opcode and fields.
module instr_packer
    import cpu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  op1,
    input  logic [3:0]  op2,
    input  logic [3:0]  low,
    input  logic [11:0] imm,
    output logic [15:0] word,
    output itype_e      itype
);

    always_comb begin
        itype = classify(opcode);
        case (itype)
            ITYPE_A, ITYPE_B: word = {opcode, op1, op2, low};
            ITYPE_C:          word = {opcode, op1, imm[7:0]};
            // Undefined opcodes share the wide-constant layout.
            default:          word = {opcode, imm};
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Streams instruction beats into instruction memory, one word per cycle, until halt or
// the last address. Optional LOADER_ILLEGAL_CHECK_EN rejects undefined opcodes.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_op1,
    input  logic [3:0]        in_op2,
    input  logic [3:0]        in_low,
    input  logic [11:0]       in_const,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
`ifdef LOADER_ILLEGAL_CHECK_EN
    localparam bit CHECK_ILLEGAL = 1'b1;
`else
    localparam bit CHECK_ILLEGAL = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;
    logic               term_q, term_d;

    logic [15:0]        pk_word;
    itype_e             pk_type;
    logic               accept, reject, wr_take, is_halt, at_last, session_start;

    instr_packer u_packer (
        .opcode (in_opcode),
        .op1    (in_op1),
        .op2    (in_op2),
        .low    (in_low),
        .imm    (in_const),
        .word   (pk_word),
        .itype  (pk_type)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= BASE;
            next_addr_q <= BASE;
            wdata_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            term_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            term_q      <= term_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            // The terminating word is on the write port this cycle.
            ST_RUN:  if (term_q) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        in_ready = (state_q == ST_RUN) && !term_q;
    end

    always_comb begin
        accept        = in_valid && in_ready;
        reject        = CHECK_ILLEGAL && (pk_type == ITYPE_UNDEF);
        wr_take       = accept && !reject;
        is_halt       = (in_opcode == OP_HALT);
        at_last       = (next_addr_q == LAST);
        session_start = start && (state_q != ST_RUN);

        we_d        = 1'b0;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        term_d      = 1'b0;

        if (session_start) begin
            addr_d      = BASE;
            next_addr_d = BASE;
            count_d     = '0;
            overflow_d  = 1'b0;
            illegal_d   = 1'b0;
        end else if (wr_take) begin
            we_d        = 1'b1;
            wdata_d     = pk_word;
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            count_d     = count_q + 1'b1;
            term_d      = is_halt || at_last;
            if (at_last && !is_halt) overflow_d = 1'b1;
        end else if (accept) begin
            illegal_d = 1'b1;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign overflow   = overflow_q;
    assign illegal    = CHECK_ILLEGAL && illegal_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (ADDR_W=8 and ADDR_W=2) share stimulus
// and are compared every cycle against a session-level model plus literal expectations.
module tb_program_loader;

`ifdef LOADER_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [3:0]  in_opcode, in_op1, in_op2, in_low;
    logic [11:0] in_const;

    logic        rdy0, we0, busy0, done0, ovf0, ill0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic [8:0]  wc0;
    logic        rdy1, we1, busy1, done1, ovf1, ill1;
    logic [1:0]  addr1;
    logic [15:0] wdata1;
    logic [2:0]  wc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .in_low(in_low),
        .in_const(in_const), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .busy(busy0), .done(done0), .overflow(ovf0), .illegal(ill0), .word_count(wc0)
    );

    program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .in_low(in_low),
        .in_const(in_const), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .busy(busy1), .done(done1), .overflow(ovf1), .illegal(ill1), .word_count(wc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Session-level model: phase 0 idle, 1 loading, 2 finished.
    function automatic logic [15:0] pack(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] lo,
                                         input logic [11:0] c);
        case (op)
            4'hF, 4'hA, 4'hB, 4'hC, 4'hD:       return {op, a, b, lo};
            4'h1, 4'h2, 4'h4, 4'h5, 4'h6:       return {op, a, c[7:0]};
            default:                            return {op, c};
        endcase
    endfunction

    function automatic bit undefined_op(input logic [3:0] op);
        return (op == 4'h3) || (op == 4'h8) || (op == 4'h9) || (op == 4'hE);
    endfunction

    int          m_phase[2], m_count[2];
    bit          m_closing[2], m_we[2], m_ovf[2], m_ill[2];
    int          m_addr[2];
    logic [15:0] m_data[2];
    bit          mvalid = 1'b0;

    task automatic model_step(input int k);
        int cap;
        cap = (k == 0) ? 256 : 4;
        if (rst) begin
            m_phase[k] = 0; m_count[k] = 0; m_closing[k] = 1'b0; m_we[k] = 1'b0;
            m_addr[k] = 0; m_data[k] = 16'h0; m_ovf[k] = 1'b0; m_ill[k] = 1'b0;
        end else begin
            m_we[k] = 1'b0;
            if (start && m_phase[k] != 1) begin
                m_phase[k] = 1; m_count[k] = 0; m_closing[k] = 1'b0;
                m_ovf[k] = 1'b0; m_ill[k] = 1'b0; m_addr[k] = 0;
            end else if (m_phase[k] == 1 && m_closing[k]) begin
                m_phase[k] = 2;
                m_closing[k] = 1'b0;
            end else if (m_phase[k] == 1 && in_valid) begin
                if (ILL_EN && undefined_op(in_opcode)) begin
                    m_ill[k] = 1'b1;
                end else begin
                    m_we[k]   = 1'b1;
                    m_addr[k] = m_count[k];
                    m_data[k] = pack(in_opcode, in_op1, in_op2, in_low, in_const);
                    m_count[k]++;
                    if (in_opcode == 4'h0) m_closing[k] = 1'b1;
                    else if (m_count[k] == cap) begin
                        m_ovf[k] = 1'b1;
                        m_closing[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("m0_ready", rdy0, (m_phase[0] == 1) && !m_closing[0]);
            check("m0_we", we0, m_we[0]);
            check("m0_addr", addr0, m_addr[0]);
            check("m0_wdata", wdata0, m_data[0]);
            check("m0_busy", busy0, m_phase[0] == 1);
            check("m0_done", done0, m_phase[0] == 2);
            check("m0_ovf", ovf0, m_ovf[0]);
            check("m0_ill", ill0, m_ill[0]);
            check("m0_count", wc0, m_count[0]);
            check("m1_ready", rdy1, (m_phase[1] == 1) && !m_closing[1]);
            check("m1_we", we1, m_we[1]);
            check("m1_addr", addr1, m_addr[1]);
            check("m1_wdata", wdata1, m_data[1]);
            check("m1_busy", busy1, m_phase[1] == 1);
            check("m1_done", done1, m_phase[1] == 2);
            check("m1_ovf", ovf1, m_ovf[1]);
            check("m1_ill", ill1, m_ill[1]);
            check("m1_count", wc1, m_count[1]);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one beat and return in the cycle after dut0 accepts it.
    task automatic beat(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] lo, input logic [11:0] c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_opcode = op; in_op1 = a; in_op2 = b; in_low = lo; in_const = c;
        for (int n = 0; n < 20; n++) begin
            ok = rdy0;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=%0d required=1", ok);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_op1 = '0; in_op2 = '0; in_low = '0; in_const = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rdy0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_addr", addr0, 0);
        check("rst_wdata", wdata0, 0);
        check("rst_count", wc0, 0);
        rst = 1'b0;

        do_start();
        check("start_busy", busy0, 1);
        check("start_ready", rdy0, 1);

        beat(4'hF, 4'h1, 4'h2, 4'h0, 12'h000);
        check("a_we", we0, 1);
        check("a_addr", addr0, 0);
        check("a_wdata", wdata0, 16'hF120);
        beat(4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
        check("halt1_ready", rdy0, 0);
        check("halt1_addr", addr0, 1);
        @(posedge clk); #1;
        check("halt1_done", done0, 1);

        do_start();
        check("restart_addr", addr0, 0);
        check("restart_count", wc0, 0);
        check("restart_ovf", ovf0, 0);
        check("restart_done", done0, 0);

        beat(4'h1, 4'h3, 4'h0, 4'h0, 12'h0A5);
        check("c_wdata", wdata0, 16'h13A5);
        check("c_addr", addr0, 0);
        beat(4'h7, 4'h0, 4'h0, 4'h0, 12'h123);
        check("d_wdata", wdata0, 16'h7123);
        check("d_addr", addr0, 1);
        beat(4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
        check("halt2_wdata", wdata0, 16'h0000);
        check("halt2_addr", addr0, 2);
        check("halt2_ready", rdy0, 0);
        @(posedge clk); #1;
        check("halt2_done", done0, 1);
        check("halt2_count", wc0, 3);
        check("halt2_we", we0, 0);

        do_start();
        for (int i = 0; i < 4; i++) begin
            beat(4'hA, 4'(i), 4'(i + 1), 4'(i + 2), 12'h000);
            check("ovf_we", we1, 1);
            check("ovf_addr", addr1, i);
        end
        check("ovf_flag", ovf1, 1);
        check("ovf_wdata", wdata1, 16'hA345);
        beat(4'hB, 4'h9, 4'h9, 4'h9, 12'h000);
        check("ovf_no5th", we1, 0);
        check("ovf_count", wc1, 4);
        check("ovf_done", done1, 1);

        beat(4'h8, 4'h1, 4'h2, 4'h3, 12'h456);
`ifdef LOADER_ILLEGAL_CHECK_EN
        check("ill_we", we0, 0);
        check("ill_flag", ill0, 1);
`else
        check("ill_we", we0, 1);
        check("ill_wdata", wdata0, 16'h8456);
        check("ill_flag", ill0, 0);
`endif

        beat(4'hC, 4'h5, 4'h6, 4'h7, 12'h000);
        check("pre_rst_wdata", wdata0, 16'hC567);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_we", we0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_ready", rdy0, 0);
        check("mid_rst_addr", addr0, 0);
        check("mid_rst_wdata", wdata0, 0);
        check("mid_rst_count", wc0, 0);
        check("mid_rst_ovf1", ovf1, 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning first word address written after start.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load session.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_opcode input 4, in_op1 input 4, in_op2 input 4, in_low input 4 (funct or offset), in_const input 12: one instruction per valid&ready beat.
REQ-006 SHALL have ports imem_we output 1, imem_addr output ADDR_W, imem_wdata output 16: instruction-memory write port.
REQ-007 SHALL have ports busy output 1, done output 1, overflow output 1, illegal output 1, word_count output ADDR_W+1.

Function
REQ-008 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE after the halt write or the last-address write; DONE -> RUN on start; start in RUN ignored.
REQ-009 SHALL drive in_ready=1 only in RUN and only while no terminating word is accepted or pending.
REQ-010 SHALL pack each beat by opcode: type A (1111) = {opcode,op1,op2,low}; type B (1010,1011,1100,1101) = {opcode,op1,op2,low}; type C (0001,0010,0100,0101,0110) = {opcode,op1,const[7:0]}; type D (0111,0000) = {opcode,const[11:0]}.
REQ-011 SHALL register the packed word and pulse imem_we exactly one cycle after the accepting beat; sustained throughput one word per cycle.
REQ-012 SHALL start imem_addr at BASE_ADDR on each start and increment by one per write; word_count SHALL count writes this session.
REQ-013 SHALL treat opcode 0000 (halt) as terminating: write it, then enter DONE; in_ready low from the cycle after acceptance.
REQ-014 SHALL, when a write targets address 2^ADDR_W-1 and is not halt, set overflow and enter DONE after that write; no address wrap.
REQ-015 SHALL hold done=1 in DONE, busy=1 in RUN, both 0 in IDLE.
REQ-016 SHALL clear overflow, illegal and word_count on start.

Reset
REQ-017 SHALL, on rst, enter IDLE; in_ready, imem_we, busy, done, overflow, illegal = 0; imem_addr = BASE_ADDR; imem_wdata = 0; word_count = 0.
REQ-018 SHALL, on rst mid-session, drop imem_we in the cycle following the reset edge and discard any pending word.
REQ-019 SHALL give rst priority over start and in_valid in the same cycle.

Configuration
REQ-020 SHALL, with LOADER_ILLEGAL_CHECK_EN defined, reject opcodes 0011, 1000, 1001, 1110: beat accepted, no write, illegal set sticky, session continues.
REQ-021 SHALL, without LOADER_ILLEGAL_CHECK_EN, pack undefined opcodes as type D and write them; illegal tied 0.

Structure
REQ-022 SHALL place opcode constants, the instruction-type enumeration (A/B/C/D/undefined) and FSM state encoding in a shared package cpu_pkg used also by the control decoder.
REQ-023 SHALL implement packing as one combinational sub-module instr_packer (opcode plus fields in, 16-bit word and type out).

Verification
REQ-024 SHALL cover: rst, start, beat opcode 1111 op1=1 op2=2 low=0 -> next cycle imem_we=1, addr=0, wdata=0xF120.
REQ-025 SHALL cover: back-to-back beats 0001 op1=3 const=0xA5, then 0111 const=0x123, then 0000 -> writes 0x13A5@0, 0x7123@1, 0x0000@2; done=1; word_count=3; in_ready=0 after halt accepted.
REQ-026 SHALL cover: ADDR_W=2, four non-halt beats -> writes at 0..3, overflow=1, done=1, no fifth write.
REQ-027 SHALL cover: rst asserted the cycle after a beat is accepted -> no imem_we in the cycle following the reset edge; all outputs at reset values.
REQ-028 SHALL cover: opcode 1000 -> with LOADER_ILLEGAL_CHECK_EN defined, no write and illegal=1; without it, word 0x8xxx written and illegal=0.
REQ-029 SHALL cover: start while in DONE -> addr restarts at BASE_ADDR, word_count=0, flags cleared.
